// File: rtl/hsid_pkg.sv
// Shared types and defaults for the HSI pixel-identification core.
package hsid_pkg;

    localparam int HSID_WORD_WIDTH   = 32;
    localparam int HSID_DATA_WIDTH   = 16;
    localparam int HSID_BANDS_MAX    = 256;
    localparam int HSID_LIBRARY_SIZE = 4096;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        STREAM = 3'd2,
        DRAIN  = 3'd3,
        FINISH = 3'd4
    } hsid_main_v2_state_t;

    typedef enum logic {
        DIST_MSE = 1'b0,
        DIST_SAD = 1'b1
    } hsid_dist_mode_t;

    function automatic logic [31:0] ceil_div(input logic [31:0] n, input logic [31:0] d);
        return (n + d - 32'd1) / d;
    endfunction

endpackage

// File: rtl/hsid_lane_dist.sv
// Stage-1 lane array: per-lane |a-b|, squared or absolute term, band mask,
// registered terms and their combinational lane sum.
module hsid_lane_dist
    import hsid_pkg::*;
#(
    parameter int DATA_WIDTH       = 16,
    parameter int SAMPLES_PER_WORD = 2,
    parameter int ACC_WIDTH        = 40
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   en,
    input  hsid_dist_mode_t                        mode,
    input  logic [SAMPLES_PER_WORD*DATA_WIDTH-1:0] meas,
    input  logic [SAMPLES_PER_WORD*DATA_WIDTH-1:0] data,
    input  logic [SAMPLES_PER_WORD-1:0]            lane_en,
    output logic [ACC_WIDTH-1:0]                   lane_sum
);

    localparam int TW = 2 * DATA_WIDTH;

    logic [DATA_WIDTH-1:0] diff_s [SAMPLES_PER_WORD];
    logic [TW-1:0]         term_s [SAMPLES_PER_WORD];
    logic [TW-1:0]         term_r [SAMPLES_PER_WORD];

    // Per-lane distance term; masked lanes contribute nothing.
    always_comb begin
        for (int l = 0; l < SAMPLES_PER_WORD; l++) begin
            diff_s[l] = '0;
            term_s[l] = '0;
        end
        for (int l = 0; l < SAMPLES_PER_WORD; l++) begin
            if (meas[l*DATA_WIDTH +: DATA_WIDTH] >= data[l*DATA_WIDTH +: DATA_WIDTH]) begin
                diff_s[l] = meas[l*DATA_WIDTH +: DATA_WIDTH] - data[l*DATA_WIDTH +: DATA_WIDTH];
            end else begin
                diff_s[l] = data[l*DATA_WIDTH +: DATA_WIDTH] - meas[l*DATA_WIDTH +: DATA_WIDTH];
            end
            if (!lane_en[l]) begin
                term_s[l] = '0;
            end else if (mode == DIST_SAD) begin
                term_s[l] = TW'(diff_s[l]);
            end else begin
                term_s[l] = TW'(diff_s[l]) * TW'(diff_s[l]);
            end
        end
    end

    // Term registers, loaded only when a library word is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int l = 0; l < SAMPLES_PER_WORD; l++) begin
                term_r[l] <= '0;
            end
        end else if (en) begin
            term_r <= term_s;
        end
    end

    // Sum of registered lane terms feeding the accumulator stage.
    always_comb begin
        lane_sum = '0;
        for (int l = 0; l < SAMPLES_PER_WORD; l++) begin
            lane_sum = lane_sum + ACC_WIDTH'(term_r[l]);
        end
    end

endmodule

// File: rtl/hsid_main_v2.sv
// HSI pixel-identification core: stores a measured vector, streams library
// vectors against it, emits per-vector MSE/SAD distances and tracks extrema.
module hsid_main_v2
    import hsid_pkg::*;
#(
    parameter int WORD_WIDTH       = HSID_WORD_WIDTH,
    parameter int DATA_WIDTH       = HSID_DATA_WIDTH,
    parameter int SAMPLES_PER_WORD = WORD_WIDTH / DATA_WIDTH,
    parameter int HSI_BANDS_MAX    = HSID_BANDS_MAX,
    parameter int HSI_LIBRARY_SIZE = HSID_LIBRARY_SIZE,
    parameter int ACC_WIDTH        = 2 * DATA_WIDTH + $clog2(HSI_BANDS_MAX)
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  start,
    input  logic                                  mode,
    input  logic [$clog2(HSI_BANDS_MAX+1)-1:0]    hsi_bands_in,
    input  logic [$clog2(HSI_LIBRARY_SIZE+1)-1:0] library_size_in,
    input  logic                                  in_valid,
    input  logic [WORD_WIDTH-1:0]                 in_data,
    output logic                                  in_ready,
    input  logic                                  clear,
    output logic                                  result_valid,
    output logic [WORD_WIDTH-1:0]                 result_value,
    output logic [$clog2(HSI_LIBRARY_SIZE)-1:0]   result_ref,
    output logic [WORD_WIDTH-1:0]                 min_value,
    output logic [WORD_WIDTH-1:0]                 max_value,
    output logic [$clog2(HSI_LIBRARY_SIZE)-1:0]   min_ref,
    output logic [$clog2(HSI_LIBRARY_SIZE)-1:0]   max_ref,
    output logic                                  done,
    output logic                                  idle
);

    localparam int DEPTH = (HSI_BANDS_MAX + SAMPLES_PER_WORD - 1) / SAMPLES_PER_WORD;
    localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int BW    = $clog2(HSI_BANDS_MAX + 1);
    localparam int LW    = $clog2(HSI_LIBRARY_SIZE + 1);
    localparam int RW    = $clog2(HSI_LIBRARY_SIZE);

    hsid_main_v2_state_t state_r, state_nxt;
    hsid_dist_mode_t     mode_r;
    logic [BW-1:0]         bands_r;
    logic [CW-1:0]         words_r;
    logic [LW-1:0]         lib_r;
    logic [IW-1:0]         widx_r;
    logic [RW-1:0]         vidx_r;
    logic [WORD_WIDTH-1:0] store [DEPTH];

    logic                  accept_s, stream_acc_s, last_word_s, last_vec_s;
    logic [SAMPLES_PER_WORD-1:0] lane_en_s;
    logic [ACC_WIDTH-1:0]  lane_sum_s, sum_s, acc_r;
    logic [WORD_WIDTH-1:0] sat_s;
    logic                  s1_valid_r, s1_first_r, s1_last_r;
    logic [RW-1:0]         s1_ref_r;

    assign in_ready     = (state_r == LOAD) || (state_r == STREAM);
    assign idle         = (state_r == IDLE);
    assign done         = (state_r == FINISH);
    assign accept_s     = in_valid && in_ready;
    assign stream_acc_s = accept_s && (state_r == STREAM);
    assign last_word_s  = (32'(widx_r) == 32'(words_r) - 32'd1);
    assign last_vec_s   = (32'(vidx_r) == 32'(lib_r) - 32'd1);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt;
        end
    end

    // Next-state logic; empty runs skip straight to FINISH.
    always_comb begin
        state_nxt = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    if ((hsi_bands_in == '0) || (library_size_in == '0)) begin
                        state_nxt = FINISH;
                    end else begin
                        state_nxt = LOAD;
                    end
                end else begin
                    state_nxt = IDLE;
                end
            end
            LOAD: begin
                if (accept_s && last_word_s) state_nxt = STREAM;
                else                         state_nxt = LOAD;
            end
            STREAM: begin
                if (accept_s && last_word_s && last_vec_s) state_nxt = DRAIN;
                else                                       state_nxt = STREAM;
            end
            DRAIN: begin
                if (!s1_valid_r) state_nxt = FINISH;
                else             state_nxt = DRAIN;
            end
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Run configuration latch plus word/vector counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_r  <= DIST_MSE;
            bands_r <= '0;
            words_r <= '0;
            lib_r   <= '0;
            widx_r  <= '0;
            vidx_r  <= '0;
        end else if ((state_r == IDLE) && start) begin
            mode_r  <= hsid_dist_mode_t'(mode);
            bands_r <= hsi_bands_in;
            words_r <= CW'(ceil_div(32'(hsi_bands_in), 32'(SAMPLES_PER_WORD)));
            lib_r   <= library_size_in;
            widx_r  <= '0;
            vidx_r  <= '0;
        end else if (accept_s) begin
            widx_r <= last_word_s ? '0 : widx_r + IW'(1);
            if ((state_r == STREAM) && last_word_s) vidx_r <= vidx_r + RW'(1);
        end
    end

    // Measured-vector store.
    always_ff @(posedge clk) begin
        if ((state_r == LOAD) && accept_s) store[widx_r] <= in_data;
    end

    // Lanes beyond the band count in the last word are masked.
    always_comb begin
        lane_en_s = '0;
        for (int l = 0; l < SAMPLES_PER_WORD; l++) begin
            lane_en_s[l] = (32'(widx_r) * 32'(SAMPLES_PER_WORD) + 32'(l)) < 32'(bands_r);
        end
    end

    hsid_lane_dist #(
        .DATA_WIDTH       (DATA_WIDTH),
        .SAMPLES_PER_WORD (SAMPLES_PER_WORD),
        .ACC_WIDTH        (ACC_WIDTH)
    ) u_lane_dist (
        .clk      (clk),
        .rst      (rst),
        .en       (stream_acc_s),
        .mode     (mode_r),
        .meas     (store[widx_r]),
        .data     (in_data),
        .lane_en  (lane_en_s),
        .lane_sum (lane_sum_s)
    );

    // Stage-1 sideband travelling with the lane terms.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_first_r <= 1'b0;
            s1_last_r  <= 1'b0;
            s1_ref_r   <= '0;
        end else begin
            s1_valid_r <= stream_acc_s;
            if (stream_acc_s) begin
                s1_first_r <= (widx_r == '0);
                s1_last_r  <= last_word_s;
                s1_ref_r   <= vidx_r;
            end
        end
    end

    assign sum_s = (s1_first_r ? '0 : acc_r) + lane_sum_s;
    assign sat_s = (|sum_s[ACC_WIDTH-1:WORD_WIDTH]) ? '1 : sum_s[WORD_WIDTH-1:0];

    // Stage 2: accumulate and publish the saturated per-vector distance.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r        <= '0;
            result_valid <= 1'b0;
            result_value <= '0;
            result_ref   <= '0;
        end else begin
            result_valid <= s1_valid_r && s1_last_r;
            if (s1_valid_r) acc_r <= sum_s;
            if (s1_valid_r && s1_last_r) begin
                result_value <= sat_s;
                result_ref   <= s1_ref_r;
            end
        end
    end

    // Extrema trackers; strict compares keep the earlier ref on ties.
    always_ff @(posedge clk) begin
        if (rst || (clear && (state_r == IDLE))) begin
            min_value <= '1;
            max_value <= '0;
            min_ref   <= '0;
            max_ref   <= '0;
        end else if (s1_valid_r && s1_last_r) begin
            if (sat_s < min_value) begin
                min_value <= sat_s;
                min_ref   <= s1_ref_r;
            end
            if (sat_s > max_value) begin
                max_value <= sat_s;
                max_ref   <= s1_ref_r;
            end
        end
    end

endmodule

// File: doc/hsid_main_v2.md
Name: hsid_main_v2

Overview:
Next-generation HSI pixel-identification core. It stores one measured pixel vector, then streams HSI_LIBRARY vectors against it and computes a per-vector distance. Distance is MSE-style (sum of squared differences) or SAD (sum of absolute differences), selected at run time. SAMPLES_PER_WORD samples are packed per input word, and the core tracks the min/max distance with its library index. It sits between the bus-side input stream and the result registers of the identification accelerator.

Parameters:
WORD_WIDTH, 32, input word and result width
DATA_WIDTH, 16, unsigned sample width; WORD_WIDTH must be a multiple of it
SAMPLES_PER_WORD, WORD_WIDTH/DATA_WIDTH, lanes per word
HSI_BANDS_MAX, 256, max bands per vector; sets measure store depth ceil(HSI_BANDS_MAX/SAMPLES_PER_WORD)
HSI_LIBRARY_SIZE, 4096, max library vectors
ACC_WIDTH, 2*DATA_WIDTH+$clog2(HSI_BANDS_MAX), internal accumulator width

Ports:
clk  in  1  clock
rst  in  1  reset; one clock; reset is synchronous and active-high
start  in  1  begin run; sampled only in IDLE
mode  in  1  0=squared differences (MSE), 1=SAD; latched at start
hsi_bands_in  in  $clog2(HSI_BANDS_MAX+1)  bands per vector; latched at start
library_size_in  in  $clog2(HSI_LIBRARY_SIZE+1)  vectors to process; latched at start
in_valid  in  1  input word valid
in_data  in  WORD_WIDTH  packed samples; lane 0 = bits [DATA_WIDTH-1:0]
in_ready  out  1  core accepts word
clear  in  1  reset min/max trackers
result_valid  out  1  one-cycle pulse per library vector
result_value  out  WORD_WIDTH  distance of that vector
result_ref  out  $clog2(HSI_LIBRARY_SIZE)  library index of that vector
min_value, max_value  out  WORD_WIDTH  tracked extrema
min_ref, max_ref  out  $clog2(HSI_LIBRARY_SIZE)  indices of extrema
done  out  1  one-cycle pulse at end of run
idle  out  1  high in IDLE

Behaviour:
- Reset: state IDLE; in_ready=0, result_valid=0, done=0, idle=1; result_value/ref=0; min_value=all-ones, max_value=0, min_ref=max_ref=0; word and vector counters 0. Reset mid-run aborts immediately; partial sums are discarded.
- Word count per vector: W = ceil(bands/SAMPLES_PER_WORD). Lanes with index >= bands in the last word are masked to contribute 0.
- FSM: IDLE -start-> LOAD (when bands==0 or lib==0: -> FINISH directly). LOAD: in_ready=1; each accepted word is written to measure store[widx]; after W words -> STREAM. STREAM: in_ready=1; each accepted word is paired with store[widx]; widx wraps to 0 after W words and vector counter increments; after the last word of the last vector -> DRAIN. DRAIN waits for the pipeline to empty -> FINISH. FINISH: done=1 for one cycle -> IDLE.
- Handshake: a word is accepted when in_valid && in_ready. Gaps in in_valid are allowed. in_ready=0 in IDLE, DRAIN, FINISH.
- Pipeline: stage 1 registers per-lane |a-b| (DATA_WIDTH bits) and term = square (2*DATA_WIDTH bits) or abs. Stage 2 adds the lane sum into the accumulator; on the first word of a vector the accumulator loads the sum instead of adding. result_valid pulses 2 cycles after the last word of a vector is accepted. result_ref is the vector index starting at 0.
- Result: the accumulator saturates to WORD_WIDTH (all-ones when overflowing). No normalisation by bands.
- Tracking: on each result, min updates if value < min_value (strict), and max updates if value > max_value (strict). Ties keep the earlier ref. The first result of a run after a clear therefore initialises both trackers. Trackers persist across runs until clear.
- clear: honoured only in IDLE and takes the reset values next cycle; ignored in other states. start is ignored outside IDLE. When start and clear coincide in IDLE, clear is applied and the run starts.
- Back-to-back: result_valid of the final vector precedes done by at least 1 cycle.

Decomposition:
- hsid_pkg: add hsid_main_v2_state_t (IDLE, LOAD, STREAM, DRAIN, FINISH) and hsid_dist_mode_t (DIST_MSE, DIST_SAD).
- Sub-module hsid_lane_dist: a combinational-plus-register stage-1 lane array (per-lane diff, abs/square, mask, lane sum) parametrised on SAMPLES_PER_WORD and DATA_WIDTH.
- The measure store is an inferred register array.

Test Plan:
- MSE, bands=4, lib=2, measure {1,2,3,4}, refs {1,2,3,4},{2,4,6,8} -> results 0@ref0, 30@ref1; min 0/ref0, max 30/ref1; done 1 cycle after last result_valid.
- SAD, same stimulus -> results 0, 10; max 10/ref1.
- Odd bands=3, measure {5,5,5,999}, ref {6,6,6,0} -> MSE 3 (padding lane masked).
- Saturation: bands=2, measure {0,0}, ref {65535,65535}, MSE -> result_value 0xFFFFFFFF.
- Ties plus random in_valid gaps: lib=3, all refs giving 7 -> min_ref=max_ref=0. Second run without clear giving 5 and 9 -> min 5, max 9.
- rst asserted mid-STREAM -> next cycle idle=1, in_ready=0, min=0xFFFFFFFF, max=0, no result_valid. clear in STREAM is ignored.
